// File: rtl/axi_pkg.sv
// Shared AXI read-path definitions: burst/resp encodings, the latched AR
// request payload and the read arbiter state encoding.
package axi_pkg;

    localparam int unsigned AXI_ADDR_W  = 64;
    localparam int unsigned AXI_DATA_W  = 128;
    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Master index used for grant/prio: 0 = icache, 1 = dcache
    localparam logic MST_ICACHE = 1'b0;
    localparam logic MST_DCACHE = 1'b1;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_rr_arb2.sv
// 2-way round-robin grant. The priority flop toggles on every upd_en pulse
// (end of a granted burst); grant itself is purely combinational.
//   clock, reset : clock, synchronous active-high reset
//   req[1:0]     : request vector (bit 0 icache, bit 1 dcache)
//   upd_en       : pass priority to the other master
//   gnt_c[1:0]   : one-hot (or zero) combinational grant
module axi_rr_arb2
    import axi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic [1:0] gnt_c
);

    logic prio_q;

    // Priority pointer: reset favours icache
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q <= MST_ICACHE;
        end else if (upd_en) begin
            prio_q <= ~prio_q;
        end
    end

    // Single request wins outright; a tie goes to the prioritised master
    always_comb begin
        gnt_c = 2'b00;
        if (req == 2'b11) begin
            gnt_c[prio_q] = 1'b1;
        end else begin
            gnt_c = req;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Blocking AXI read arbiter: icache and dcache AR requests share one SoC read
// port, one burst outstanding; the R burst is steered back to the grantee.
// A sticky error flags stray beats, ID mismatches and beat-count mismatches.
//   clock/reset               : clock, synchronous active-high reset
//   icache2axi_arbiter_*      : icache AR request and R ready
//   axi_arbiter2icache_*      : icache AR ready and R beat
//   dcache2axi_arbiter_*      : dcache AR request and R ready
//   axi_arbiter2dcache_*      : dcache AR ready and R beat
//   axi_arbiter2axi_*         : AR request and R ready to the SoC bus
//   axi2axi_arbiter_*         : AR ready and R beat from the SoC bus
//   axi_arbiter_err           : sticky protocol error
module axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              icache2axi_arbiter_arvalid,
    input  logic [ADDR_W-1:0] icache2axi_arbiter_araddr,
    input  logic [ID_W-1:0]   icache2axi_arbiter_arid,
    input  logic [7:0]        icache2axi_arbiter_arlen,
    input  logic [2:0]        icache2axi_arbiter_arsize,
    input  logic [1:0]        icache2axi_arbiter_arburst,
    output logic              axi_arbiter2icache_arready,
    output logic              axi_arbiter2icache_rvalid,
    output logic [1:0]        axi_arbiter2icache_rresp,
    output logic [DATA_W-1:0] axi_arbiter2icache_rdata,
    output logic              axi_arbiter2icache_rlast,
    output logic [ID_W-1:0]   axi_arbiter2icache_rid,
    input  logic              icache2axi_arbiter_rready,

    input  logic              dcache2axi_arbiter_arvalid,
    input  logic [ADDR_W-1:0] dcache2axi_arbiter_araddr,
    input  logic [ID_W-1:0]   dcache2axi_arbiter_arid,
    input  logic [7:0]        dcache2axi_arbiter_arlen,
    input  logic [2:0]        dcache2axi_arbiter_arsize,
    input  logic [1:0]        dcache2axi_arbiter_arburst,
    output logic              axi_arbiter2dcache_arready,
    output logic              axi_arbiter2dcache_rvalid,
    output logic [1:0]        axi_arbiter2dcache_rresp,
    output logic [DATA_W-1:0] axi_arbiter2dcache_rdata,
    output logic              axi_arbiter2dcache_rlast,
    output logic [ID_W-1:0]   axi_arbiter2dcache_rid,
    input  logic              dcache2axi_arbiter_rready,

    output logic              axi_arbiter2axi_arvalid,
    output logic [ADDR_W-1:0] axi_arbiter2axi_araddr,
    output logic [ID_W-1:0]   axi_arbiter2axi_arid,
    output logic [7:0]        axi_arbiter2axi_arlen,
    output logic [2:0]        axi_arbiter2axi_arsize,
    output logic [1:0]        axi_arbiter2axi_arburst,
    input  logic              axi2axi_arbiter_arready,

    input  logic              axi2axi_arbiter_rvalid,
    input  logic [1:0]        axi2axi_arbiter_rresp,
    input  logic [DATA_W-1:0] axi2axi_arbiter_rdata,
    input  logic              axi2axi_arbiter_rlast,
    input  logic [ID_W-1:0]   axi2axi_arbiter_rid,
    output logic              axi_arbiter2axi_rready,

    output logic              axi_arbiter_err
);

    import axi_pkg::*;

    arb_state_e     state_q;
    arb_state_e     state_d;
    ar_req_t        ar_q;
    ar_req_t        req_sel;
    logic           grant_q;
    logic [7:0]     beat_cnt_q;
    logic [1:0]     arb_req;
    logic [1:0]     arb_gnt;
    logic           ar_hs;
    logic           beat;
    logic           burst_end;
    logic           err_set;

    assign arb_req = {dcache2axi_arbiter_arvalid, icache2axi_arbiter_arvalid};

    axi_rr_arb2 u_rr_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (arb_req),
        .upd_en (burst_end),
        .gnt_c  (arb_gnt)
    );

    // Payload of the arbitration winner, captured on the AR handshake
    always_comb begin
        if (arb_gnt[1]) begin
            req_sel.addr  = AXI_ADDR_W'(dcache2axi_arbiter_araddr);
            req_sel.id    = AXI_ID_W'(dcache2axi_arbiter_arid);
            req_sel.len   = dcache2axi_arbiter_arlen;
            req_sel.size  = dcache2axi_arbiter_arsize;
            req_sel.burst = dcache2axi_arbiter_arburst;
        end else begin
            req_sel.addr  = AXI_ADDR_W'(icache2axi_arbiter_araddr);
            req_sel.id    = AXI_ID_W'(icache2axi_arbiter_arid);
            req_sel.len   = icache2axi_arbiter_arlen;
            req_sel.size  = icache2axi_arbiter_arsize;
            req_sel.burst = icache2axi_arbiter_arburst;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus handshake steering
    always_comb begin
        state_d                    = state_q;
        axi_arbiter2icache_arready = 1'b0;
        axi_arbiter2dcache_arready = 1'b0;
        axi_arbiter2icache_rvalid  = 1'b0;
        axi_arbiter2dcache_rvalid  = 1'b0;
        axi_arbiter2axi_rready     = 1'b0;
        ar_hs                      = 1'b0;
        beat                       = 1'b0;
        burst_end                  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // Grant only exists when its arvalid is high, so arready
                // high is always a completed handshake
                axi_arbiter2icache_arready = arb_gnt[0];
                axi_arbiter2dcache_arready = arb_gnt[1];
                if (|arb_gnt) begin
                    ar_hs   = 1'b1;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (axi2axi_arbiter_arready) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (grant_q == MST_DCACHE) begin
                    axi_arbiter2dcache_rvalid = axi2axi_arbiter_rvalid;
                    axi_arbiter2axi_rready    = dcache2axi_arbiter_rready;
                    beat = axi2axi_arbiter_rvalid & dcache2axi_arbiter_rready;
                end else begin
                    axi_arbiter2icache_rvalid = axi2axi_arbiter_rvalid;
                    axi_arbiter2axi_rready    = icache2axi_arbiter_rready;
                    beat = axi2axi_arbiter_rvalid & icache2axi_arbiter_rready;
                end
                if (beat && axi2axi_arbiter_rlast) begin
                    burst_end = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // R payload is broadcast; only the grantee's rvalid qualifies it
    assign axi_arbiter2icache_rresp = axi2axi_arbiter_rresp;
    assign axi_arbiter2icache_rdata = axi2axi_arbiter_rdata;
    assign axi_arbiter2icache_rlast = axi2axi_arbiter_rlast;
    assign axi_arbiter2icache_rid   = axi2axi_arbiter_rid;
    assign axi_arbiter2dcache_rresp = axi2axi_arbiter_rresp;
    assign axi_arbiter2dcache_rdata = axi2axi_arbiter_rdata;
    assign axi_arbiter2dcache_rlast = axi2axi_arbiter_rlast;
    assign axi_arbiter2dcache_rid   = axi2axi_arbiter_rid;

    // Bus AR channel driven straight from the state and payload registers
    assign axi_arbiter2axi_arvalid = (state_q == ARB_ADDR);
    assign axi_arbiter2axi_araddr  = ADDR_W'(ar_q.addr);
    assign axi_arbiter2axi_arid    = ID_W'(ar_q.id);
    assign axi_arbiter2axi_arlen   = ar_q.len;
    assign axi_arbiter2axi_arsize  = ar_q.size;
    assign axi_arbiter2axi_arburst = ar_q.burst;

    // beat_cnt counts beats already taken, so the final beat sees arlen
    assign err_set = (axi2axi_arbiter_rvalid && (state_q != ARB_DATA))
                   || (beat && (AXI_ID_W'(axi2axi_arbiter_rid) != ar_q.id))
                   || (beat && axi2axi_arbiter_rlast && (beat_cnt_q != ar_q.len))
                   || (beat && !axi2axi_arbiter_rlast && (beat_cnt_q == ar_q.len));

    // Request latch, grant record, beat counter and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            ar_q            <= '0;
            grant_q         <= MST_ICACHE;
            beat_cnt_q      <= 8'd0;
            axi_arbiter_err <= 1'b0;
        end else begin
            if (ar_hs) begin
                ar_q       <= req_sel;
                grant_q    <= arb_gnt[1];
                beat_cnt_q <= 8'd0;
            end else if (beat) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            if (err_set) begin
                axi_arbiter_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: AR and R expectations are queued when
// stimulus is driven and popped when the DUT presents them.
module tb_axi_rd_arbiter;

    logic         clock;
    logic         reset;
    logic         i_arvalid, d_arvalid;
    logic [63:0]  i_araddr, d_araddr;
    logic [3:0]   i_arid, d_arid;
    logic [7:0]   i_arlen, d_arlen;
    logic [2:0]   i_arsize, d_arsize;
    logic [1:0]   i_arburst, d_arburst;
    logic         i_arready, d_arready;
    logic         i_rvalid, d_rvalid;
    logic [1:0]   i_rresp, d_rresp;
    logic [127:0] i_rdata, d_rdata;
    logic         i_rlast, d_rlast;
    logic [3:0]   i_rid, d_rid;
    logic         i_rready, d_rready;
    logic         b_arvalid, b_arready;
    logic [63:0]  b_araddr;
    logic [3:0]   b_arid;
    logic [7:0]   b_arlen;
    logic [2:0]   b_arsize;
    logic [1:0]   b_arburst;
    logic         b_rvalid, b_rlast, b_rready;
    logic [1:0]   b_rresp;
    logic [127:0] b_rdata;
    logic [3:0]   b_rid;
    logic         err;

    typedef struct {
        logic        m;
        logic [63:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        logic         m;
        logic [127:0] data;
        logic         last;
        logic [3:0]   id;
    } r_exp_t;

    ar_exp_t arq[$];
    r_exp_t  rq[$];
    int      checks   = 0;
    int      failures = 0;
    int      burst_no = 0;

    axi_rd_arbiter dut (
        .clock                      (clock),
        .reset                      (reset),
        .icache2axi_arbiter_arvalid (i_arvalid),
        .icache2axi_arbiter_araddr  (i_araddr),
        .icache2axi_arbiter_arid    (i_arid),
        .icache2axi_arbiter_arlen   (i_arlen),
        .icache2axi_arbiter_arsize  (i_arsize),
        .icache2axi_arbiter_arburst (i_arburst),
        .axi_arbiter2icache_arready (i_arready),
        .axi_arbiter2icache_rvalid  (i_rvalid),
        .axi_arbiter2icache_rresp   (i_rresp),
        .axi_arbiter2icache_rdata   (i_rdata),
        .axi_arbiter2icache_rlast   (i_rlast),
        .axi_arbiter2icache_rid     (i_rid),
        .icache2axi_arbiter_rready  (i_rready),
        .dcache2axi_arbiter_arvalid (d_arvalid),
        .dcache2axi_arbiter_araddr  (d_araddr),
        .dcache2axi_arbiter_arid    (d_arid),
        .dcache2axi_arbiter_arlen   (d_arlen),
        .dcache2axi_arbiter_arsize  (d_arsize),
        .dcache2axi_arbiter_arburst (d_arburst),
        .axi_arbiter2dcache_arready (d_arready),
        .axi_arbiter2dcache_rvalid  (d_rvalid),
        .axi_arbiter2dcache_rresp   (d_rresp),
        .axi_arbiter2dcache_rdata   (d_rdata),
        .axi_arbiter2dcache_rlast   (d_rlast),
        .axi_arbiter2dcache_rid     (d_rid),
        .dcache2axi_arbiter_rready  (d_rready),
        .axi_arbiter2axi_arvalid    (b_arvalid),
        .axi_arbiter2axi_araddr     (b_araddr),
        .axi_arbiter2axi_arid       (b_arid),
        .axi_arbiter2axi_arlen      (b_arlen),
        .axi_arbiter2axi_arsize     (b_arsize),
        .axi_arbiter2axi_arburst    (b_arburst),
        .axi2axi_arbiter_arready    (b_arready),
        .axi2axi_arbiter_rvalid     (b_rvalid),
        .axi2axi_arbiter_rresp      (b_rresp),
        .axi2axi_arbiter_rdata      (b_rdata),
        .axi2axi_arbiter_rlast      (b_rlast),
        .axi2axi_arbiter_rid        (b_rid),
        .axi_arbiter2axi_rready     (b_rready),
        .axi_arbiter_err            (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive all inputs idle and pulse reset; leaves us at posedge+1
    task automatic do_reset();
        reset = 1'b1;
        i_arvalid = 0; i_araddr = 0; i_arid = 0; i_arlen = 0; i_arsize = 0; i_arburst = 0;
        d_arvalid = 0; d_araddr = 0; d_arid = 0; d_arlen = 0; d_arsize = 0; d_arburst = 0;
        i_rready = 1'b1; d_rready = 1'b1;
        b_arready = 0; b_rvalid = 0; b_rresp = 0; b_rdata = 0; b_rlast = 0; b_rid = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic issue_req(input logic m, input logic [63:0] addr, input logic [3:0] id,
                             input logic [7:0] len);
        ar_exp_t e;
        e.m = m; e.addr = addr; e.id = id; e.len = len;
        arq.push_back(e);
        if (m) begin
            d_arvalid = 1; d_araddr = addr; d_arid = id; d_arlen = len; d_arsize = 3'd4; d_arburst = 2'b01;
        end else begin
            i_arvalid = 1; i_araddr = addr; i_arid = id; i_arlen = len; i_arsize = 3'd4; i_arburst = 2'b01;
        end
    endtask

    // Wait for the arready of master m, then confirm it lasts one cycle
    task automatic wait_grant(input logic m);
        bit got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock);
            if (i_arready || d_arready) begin
                check("arready_who", {d_arready, i_arready}, m ? 2'b10 : 2'b01);
                got = 1;
            end
            @(posedge clock); #1;
            if (got) begin
                if (m) d_arvalid = 0; else i_arvalid = 0;
            end
        end
        if (!got) check("arready_timeout", 0, 1);
        @(negedge clock);
        check("arready_one_cycle", {d_arready, i_arready}, 2'b00);
        @(posedge clock); #1;
    endtask

    // Bus slave AR side: compare payload, stall arready for delay cycles
    task automatic serve_ar(input int delay);
        bit got = 0;
        ar_exp_t e;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock);
            if (b_arvalid) got = 1;
            else begin @(posedge clock); #1; end
        end
        if (!got || arq.size() == 0) begin
            check("bus_arvalid_timeout", 0, 1);
            return;
        end
        e = arq.pop_front();
        check("bus_araddr", b_araddr, e.addr);
        check("bus_arid", b_arid, e.id);
        check("bus_arlen", b_arlen, e.len);
        check("bus_arsize", b_arsize, 3'd4);
        check("bus_arburst", b_arburst, 2'b01);
        check("busy_arready", {d_arready, i_arready}, 2'b00);
        for (int d = 0; d < delay; d++) begin
            @(posedge clock); #1;
            @(negedge clock);
            check("bus_arvalid_hold", b_arvalid, 1);
            check("bus_araddr_hold", b_araddr, e.addr);
        end
        @(posedge clock); #1 b_arready = 1;
        @(posedge clock); #1 b_arready = 0;
    endtask

    // Bus slave R side: nbeats beats, rlast on beat last_idx, optional stall
    task automatic serve_r(input logic m, input logic [3:0] rid, input int nbeats,
                           input int last_idx, input int stall_beat, input int stall_cyc);
        r_exp_t e, x;
        burst_no++;
        for (int k = 0; k < nbeats; k++) begin
            bit got = 0;
            b_rvalid = 1;
            b_rdata  = {32'(burst_no), 32'(k), 64'h0123_4567_89AB_CDEF};
            b_rlast  = (k == last_idx);
            b_rid    = rid;
            b_rresp  = 2'b00;
            e.m = m; e.data = b_rdata; e.last = b_rlast; e.id = rid;
            rq.push_back(e);
            if (k == stall_beat) begin
                if (m) d_rready = 0; else i_rready = 0;
                for (int s = 0; s < stall_cyc; s++) begin
                    @(negedge clock);
                    check("stall_bus_rready", b_rready, 0);
                    check("stall_rvalid", m ? d_rvalid : i_rvalid, 1);
                    @(posedge clock); #1;
                end
                if (m) d_rready = 1; else i_rready = 1;
            end
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clock);
                if (b_rvalid && b_rready) begin
                    x = rq.pop_front();
                    check("r_route", {d_rvalid, i_rvalid}, x.m ? 2'b10 : 2'b01);
                    check("r_data", m ? d_rdata : i_rdata, x.data);
                    check("r_last", m ? d_rlast : i_rlast, x.last);
                    check("r_id", m ? d_rid : i_rid, x.id);
                    check("r_resp", m ? d_rresp : i_rresp, 2'b00);
                    got = 1;
                end
                @(posedge clock); #1;
            end
            if (!got) check("r_beat_timeout", 0, 1);
        end
        b_rvalid = 0; b_rlast = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset state
        @(negedge clock);
        check("rst_arready", {d_arready, i_arready}, 2'b00);
        check("rst_rvalid", {d_rvalid, i_rvalid}, 2'b00);
        check("rst_bus_arvalid", b_arvalid, 0);
        check("rst_bus_rready", b_rready, 0);
        check("rst_bus_araddr", b_araddr, 0);
        check("rst_err", err, 0);
        @(posedge clock); #1;

        // Single icache burst, bus arready after 2 cycles
        issue_req(0, 64'h8000_0040, 4'h3, 8'd3);
        wait_grant(0);
        serve_ar(2);
        serve_r(0, 4'h3, 4, 3, -1, 0);
        @(negedge clock);
        check("t1_err", err, 0);
        check("t1_idle_rready", b_rready, 0);
        @(posedge clock); #1;

        // Round-robin: simultaneous requests after reset
        do_reset();
        issue_req(0, 64'h1000, 4'h3, 8'd1);
        issue_req(1, 64'h2000, 4'h9, 8'd1);
        wait_grant(0);
        serve_ar(0);
        serve_r(0, 4'h3, 2, 1, -1, 0);
        wait_grant(1);
        serve_ar(1);
        serve_r(1, 4'h9, 2, 1, -1, 0);
        issue_req(0, 64'h3000, 4'h3, 8'd0);
        issue_req(1, 64'h4000, 4'h9, 8'd0);
        wait_grant(0);
        serve_ar(0);
        serve_r(0, 4'h3, 1, 0, -1, 0);
        wait_grant(1);
        serve_ar(0);
        serve_r(1, 4'h9, 1, 0, -1, 0);
        @(negedge clock);
        check("t2_err", err, 0);
        @(posedge clock); #1;

        // Master back-pressure mid-burst
        issue_req(0, 64'h5000, 4'h3, 8'd5);
        wait_grant(0);
        serve_ar(1);
        serve_r(0, 4'h3, 6, 5, 2, 3);
        @(negedge clock);
        check("t3_err", err, 0);
        @(posedge clock); #1;

        // Early rlast: error set and sticky across a clean burst
        issue_req(0, 64'h6000, 4'h3, 8'd3);
        wait_grant(0);
        serve_ar(0);
        serve_r(0, 4'h3, 2, 1, -1, 0);
        @(negedge clock);
        check("t4_err_set", err, 1);
        @(posedge clock); #1;
        issue_req(1, 64'h7000, 4'h9, 8'd1);
        wait_grant(1);
        serve_ar(0);
        serve_r(1, 4'h9, 2, 1, -1, 0);
        @(negedge clock);
        check("t4_err_sticky", err, 1);
        @(posedge clock); #1;

        // Stray bus rvalid while IDLE
        do_reset();
        b_rvalid = 1; b_rlast = 1; b_rdata = 128'hBAD;
        @(negedge clock);
        check("t5_rvalid", {d_rvalid, i_rvalid}, 2'b00);
        check("t5_bus_rready", b_rready, 0);
        @(posedge clock); #1 b_rvalid = 0; b_rlast = 0;
        @(negedge clock);
        check("t5_err", err, 1);
        @(posedge clock); #1;

        // Reset during DATA beat 1, then a normal dcache burst
        do_reset();
        issue_req(0, 64'h9000, 4'h3, 8'd3);
        wait_grant(0);
        serve_ar(0);
        serve_r(0, 4'h3, 1, 99, -1, 0);
        b_rvalid = 1; b_rdata = 128'hABCD; b_rid = 4'h3; b_rlast = 0;
        reset = 1;
        @(posedge clock); #1 reset = 0; b_rvalid = 0;
        @(negedge clock);
        check("t6_arready", {d_arready, i_arready}, 2'b00);
        check("t6_rvalid", {d_rvalid, i_rvalid}, 2'b00);
        check("t6_bus_arvalid", b_arvalid, 0);
        check("t6_bus_rready", b_rready, 0);
        check("t6_bus_araddr", b_araddr, 0);
        check("t6_err", err, 0);
        @(posedge clock); #1;
        issue_req(1, 64'hA000, 4'h9, 8'd1);
        wait_grant(1);
        serve_ar(0);
        serve_r(1, 4'h9, 2, 1, -1, 0);
        @(negedge clock);
        check("t6_after_err", err, 0);
        check("ar_queue_empty", 32'(arq.size()), 0);
        check("r_queue_empty", 32'(rq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Sits directly downstream of the icache fill engine and the dcache miss engine.
- Arbitrates their AXI read-address requests onto the single SoC AXI read port, then routes the returned R-channel burst back to the granted requester.
- Blocking design: one burst outstanding at a time, round-robin grant, registered AR outputs.
- Includes a sticky protocol-error monitor for beat-count and ID mismatches.

Parameters:
- ADDR_W, 64, AR address width
- DATA_W, 128, R data width
- ID_W, 4, AXI ID width

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- icache2axi_arbiter_arvalid/araddr/arid/arlen/arsize/arburst  in  1/ADDR_W/ID_W/8/3/2  icache AR request
- axi_arbiter2icache_arready  out  1  icache AR accepted
- axi_arbiter2icache_rvalid/rresp/rdata/rlast/rid  out  1/2/DATA_W/1/ID_W  R beat to icache
- icache2axi_arbiter_rready  in  1  icache accepts beat
- dcache2axi_arbiter_arvalid/araddr/arid/arlen/arsize/arburst  in  1/ADDR_W/ID_W/8/3/2  dcache AR request
- axi_arbiter2dcache_arready  out  1  dcache AR accepted
- axi_arbiter2dcache_rvalid/rresp/rdata/rlast/rid  out  1/2/DATA_W/1/ID_W  R beat to dcache
- dcache2axi_arbiter_rready  in  1  dcache accepts beat
- axi_arbiter2axi_arvalid/araddr/arid/arlen/arsize/arburst  out  1/ADDR_W/ID_W/8/3/2  AR to SoC bus
- axi2axi_arbiter_arready  in  1  bus accepts AR
- axi2axi_arbiter_rvalid/rresp/rdata/rlast/rid  in  1/2/DATA_W/1/ID_W  R beat from bus
- axi_arbiter2axi_rready  out  1  R ready to bus
- axi_arbiter_err  out  1  sticky protocol error

Behaviour:
- Reset:
  - state=IDLE, prio=icache, grant=icache.
  - All arvalid/arready/rvalid/rready outputs 0; registered AR payload 0; beat_cnt 0; err 0.
  - Reset mid-burst abandons the burst; no beats are forwarded afterwards.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Winner is chosen among asserted arvalids. With one request, that master wins. With both, the master selected by prio wins.
  - The winner's arready is driven combinationally high for this cycle only. The loser's arready is 0.
  - On the handshake, the winner's araddr/arid/arlen/arsize/arburst are latched into registers, grant is recorded, beat_cnt is cleared, and the next state is ADDR.
  - Single-cycle AR acceptance latency at the master interface.
- ADDR:
  - axi_arbiter2axi_arvalid=1 with the registered payload, held stable until axi2axi_arbiter_arready.
  - On arready, the next state is DATA.
  - Minimum 1 cycle from master acceptance to bus arvalid.
- DATA:
  - Combinational pass-through: granted master's rvalid = bus rvalid; bus rready = granted master's rready; rresp/rdata/rlast/rid forwarded unchanged.
  - The non-granted master sees rvalid=0.
  - Each beat (rvalid&rready) increments the 8-bit beat_cnt.
  - A beat with rlast: next state IDLE, prio toggles to the other master.
- Both master arready outputs are 0 in ADDR and DATA; new requests wait.
- Zero-bubble return is not required: one idle cycle between bursts is allowed and expected.
- Error monitor (err is sticky until reset):
  - A beat with rid != latched arid sets err.
  - rlast with beat_cnt != latched arlen sets err.
  - beat_cnt == arlen without rlast sets err.
  - The burst still terminates only on rlast.
- Bus rvalid in IDLE/ADDR: bus rready=0, beat ignored, err set.
- Simultaneous arvalid in IDLE: exactly one arready asserted. The loser must hold its request (AXI rule) and wins next IDLE.
- arvalid deasserted mid-IDLE: no grant, no state change.

Decomposition:
- Shared package axi_pkg: AXI burst encodings (INCR=2'b01), resp codes, ar_req_t struct (addr/id/len/size/burst), arbiter state enum.
- Natural sub-module: axi_rr_arb2, a 2-way round-robin grant with the prio flop, update enable on burst end.

Test Plan:
- Only icache arvalid, araddr=0x8000_0040, arlen=3; bus arready after 2 cycles, 4 beats → icache arready high 1 cycle; bus AR payload equals request; 4 beats reach icache only; rlast returns to IDLE; err=0.
- Both request in the same cycle after reset → icache granted first, dcache granted on the next IDLE; third simultaneous request → icache again (alternation).
- Granted master drops rready for 3 cycles mid-burst → bus rready=0 during the stall; no beat lost or duplicated; rdata sequence intact.
- arlen=3 but bus asserts rlast on beat 2 → burst ends, err=1, and err stays 1 across later clean bursts.
- Bus rvalid pulsed while IDLE → no master sees rvalid; err=1.
- reset asserted during DATA beat 1 → next cycle all outputs 0, state IDLE; a subsequent dcache request is served normally.
